// File: rtl/burst_mem_pkg.sv
`default_nettype none
// =============================================================================
// burst_mem_pkg : size/burst encodings, FSM states and burst-length helper.
// Rev 1.0
// =============================================================================
package burst_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    BURST_1  = 2'd0,
    BURST_4  = 2'd1,
    BURST_8  = 2'd2,
    BURST_16 = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_ERR  = 2'd2
`ifdef BURST_MEM_WAIT_EN
    , ST_WAIT = 2'd3
`endif
  } state_e;

  function automatic logic [4:0] beats_from_burst(input logic [1:0] burst);
    case (burst)
      BURST_4:  return 5'd4;
      BURST_8:  return 5'd8;
      BURST_16: return 5'd16;
      default:  return 5'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_mem_lane_align.sv
`default_nettype none
// =============================================================================
// mem_lane_align : big-endian byte-lane extract/extend for reads, lane merge
//                  and byte enables for writes. Lowest address is beat MSB.
// Rev 1.0
// =============================================================================
module mem_lane_align
  import burst_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   mem_beat,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   wbeat,
  output logic [DATA_W/8-1:0] wbe
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_b = mem_beat[DATA_W-1 -: 8];
  assign w_h = mem_beat[DATA_W-1 -: 16];

  always_comb begin
    rdata = mem_beat;
    wbeat = wdata;
    wbe   = '1;
    case (size)
      SIZE_BYTE: begin
        rdata = {{(DATA_W-8){~is_unsigned & w_b[7]}}, w_b};
        wbeat = {wdata[7:0], {(DATA_W-8){1'b0}}};
        wbe   = (DATA_W/8)'(1);
      end
      SIZE_HALF: begin
        rdata = {{(DATA_W-16){~is_unsigned & w_h[15]}}, w_h};
        wbeat = {wdata[15:0], {(DATA_W-16){1'b0}}};
        wbe   = (DATA_W/8)'(3);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/burst_mem.sv
`default_nettype none
// =============================================================================
// burst_mem : big-endian byte-addressed memory with 1/4/8/16-beat bursts.
//             Define BURST_MEM_WAIT_EN to stall WAIT_CYCLES before each beat.
// Rev 1.0
// =============================================================================
module burst_mem
  import burst_mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                MEM_BYTES   = 1048576,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8002_0000),
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [1:0]        req_burst,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int c_nb    = DATA_W / 8;
  localparam int c_off_w = $clog2(MEM_BYTES);

`ifdef BURST_MEM_WAIT_EN
  localparam int     c_wait_w     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam state_e c_beat_entry = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BEAT;
  logic [c_wait_w-1:0] r_wait;
`else
  localparam state_e c_beat_entry = ST_BEAT;
  // WAIT_CYCLES has no effect unless stalls are compiled in.
  if (WAIT_CYCLES < 0) begin : g_wait_unused
  end
`endif

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_size;
  logic               r_wr;
  logic               r_unsigned;
  logic [4:0]         r_beat;
  logic [4:0]         r_nbeats;
  logic               r_rsp_valid;
  logic               r_rsp_last;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic [7:0]         r_mem [MEM_BYTES];

  logic               w_idle;
  logic [ADDR_W-1:0]  w_chk_addr;
  logic [1:0]         w_chk_size;
  logic [ADDR_W-1:0]  w_off;
  logic [ADDR_W:0]    w_nbytes;
  logic [ADDR_W:0]    w_end;
  logic               w_addr_err;
  logic               w_last;
  logic               w_do_write;
  logic [c_off_w-1:0] w_idx;
  logic [DATA_W-1:0]  w_mem_beat;
  logic [DATA_W-1:0]  w_rdata;
  logic [DATA_W-1:0]  w_wbeat;
  logic [c_nb-1:0]    w_wbe;

  assign w_idle     = (r_state == ST_IDLE);
  assign req_ready  = w_idle;
  assign busy       = ~w_idle;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_last   = r_rsp_last;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;

  // One range/alignment checker: the live request in IDLE, the current beat otherwise.
  assign w_chk_addr = w_idle ? req_addr : r_addr;
  assign w_chk_size = w_idle ? req_size : r_size;
  assign w_off      = w_chk_addr - BASE_ADDR;
  assign w_idx      = w_off[c_off_w-1:0];

  always_comb begin
    w_nbytes   = (ADDR_W+1)'(c_nb);
    w_addr_err = 1'b0;
    case (w_chk_size)
      SIZE_BYTE: w_nbytes = (ADDR_W+1)'(1);
      SIZE_HALF: begin
        w_nbytes   = (ADDR_W+1)'(2);
        w_addr_err = w_chk_addr[0];
      end
      SIZE_WORD: w_addr_err = |w_chk_addr[1:0];
      default:   w_addr_err = 1'b1;
    endcase
    w_end = {1'b0, w_off} + w_nbytes;
    if ((w_chk_addr < BASE_ADDR) || (w_end > (ADDR_W+1)'(MEM_BYTES))) begin
      w_addr_err = 1'b1;
    end
  end

  assign w_last     = (r_beat == (r_nbeats - 5'd1));
  assign w_do_write = (r_state == ST_BEAT) && r_wr && !w_addr_err;

  for (genvar g = 0; g < c_nb; g++) begin : g_rd_bytes
    assign w_mem_beat[DATA_W-1-8*g -: 8] = r_mem[w_idx + c_off_w'(g)];
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane (
    .mem_beat    (w_mem_beat),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .wdata       (wdata),
    .rdata       (w_rdata),
    .wbeat       (w_wbeat),
    .wbe         (w_wbe)
  );

  // Storage has no reset so contents survive an aborted burst.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < c_nb; i++) begin
        if (w_wbe[i]) r_mem[w_idx + c_off_w'(i)] <= w_wbeat[DATA_W-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_size      <= SIZE_BYTE;
      r_wr        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_beat      <= 5'd0;
      r_nbeats    <= 5'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef BURST_MEM_WAIT_EN
      r_wait      <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_wr       <= req_wr;
            r_unsigned <= req_unsigned;
            r_beat     <= 5'd0;
            r_nbeats   <= (req_size == SIZE_WORD) ? beats_from_burst(req_burst) : 5'd1;
            r_state    <= w_addr_err ? ST_ERR : c_beat_entry;
`ifdef BURST_MEM_WAIT_EN
            r_wait     <= c_wait_w'(WAIT_CYCLES - 1);
`endif
          end
        end
        ST_ERR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_last  <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_state     <= ST_IDLE;
        end
`ifdef BURST_MEM_WAIT_EN
        ST_WAIT: begin
          if (r_wait == '0) r_state <= ST_BEAT;
          else              r_wait  <= r_wait - c_wait_w'(1);
        end
`endif
        ST_BEAT: begin
          r_rsp_valid <= 1'b1;
          if (w_addr_err) begin
            // Burst ran off the end of storage: error beat terminates it.
            r_rsp_err  <= 1'b1;
            r_rsp_last <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_rsp_rdata <= r_wr ? '0 : w_rdata;
            r_rsp_last  <= w_last;
            r_beat      <= r_beat + 5'd1;
            r_addr      <= r_addr + ADDR_W'(c_nb);
            r_state     <= w_last ? ST_IDLE : c_beat_entry;
`ifdef BURST_MEM_WAIT_EN
            r_wait      <= c_wait_w'(WAIT_CYCLES - 1);
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_mem.sv
`default_nettype none
// =============================================================================
// tb_burst_mem : directed self-checking bench for burst_mem (default build).
// Rev 1.0
// =============================================================================
module tb_burst_mem;
  import burst_mem_pkg::*;

  localparam logic [31:0] BASE     = 32'h8002_0000;
  localparam logic [31:0] END_ADDR = 32'h8012_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [1:0]  req_burst = '0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic        rsp_last;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;

  always #5 clk = ~clk;

  burst_mem dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_burst    (req_burst),
    .wdata        (wdata),
    .rsp_valid    (rsp_valid),
    .rsp_last     (rsp_last),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wq [16];
  logic [31:0] got_data [17];
  logic        got_err [17];
  logic        got_last [17];
  int          nbeats;
  int          first_lat;
  int          last_cyc;
  logic        acc_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, feed wq[] per write beat, collect beats until rsp_last.
  task automatic run(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                     input logic uns, input logic [1:0] burst);
    int   cyc;
    logic done;
    cyc = 0; done = 1'b0; nbeats = 0; first_lat = -1; last_cyc = -1;
    req_addr = addr; req_wr = wr; req_size = size; req_unsigned = uns; req_burst = burst;
    wdata = wq[0]; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; acc_busy = busy;
    // Scramble the request fields; the DUT must keep using the accepted ones.
    req_addr = 32'h0; req_wr = ~wr; req_size = ~size; req_unsigned = ~uns; req_burst = ~burst;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        if (nbeats == 0) first_lat = cyc;
        last_cyc = cyc;
        if (nbeats < 17) begin
          got_data[nbeats] = rsp_rdata;
          got_err[nbeats]  = rsp_err;
          got_last[nbeats] = rsp_last;
        end
        done = rsp_last;
        nbeats++;
        if (nbeats < 16) wdata = wq[nbeats];
      end
    end
    check("no_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_last",  32'(rsp_last),  32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_rdata", rsp_rdata,      32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);

    // ---------------- word write, sub-word reads ----------------
    wq[0] = 32'hDEAD_BEEF;
    run(BASE, 1'b1, SIZE_WORD, 1'b0, BURST_1);
    check("wr_nbeats", 32'(nbeats), 32'd1);
    check("wr_lat",    32'(first_lat), 32'd1);
    check("wr_last",   32'(got_last[0]), 32'd1);
    check("wr_rdata",  got_data[0], 32'd0);
    check("wr_busy",   32'(acc_busy), 32'd1);

    run(BASE, 1'b0, SIZE_BYTE, 1'b1, BURST_1);
    check("rd_b_u0",      got_data[0], 32'h0000_00DE);
    check("rd_b_u0_last", 32'(got_last[0]), 32'd1);
    run(BASE + 32'd3, 1'b0, SIZE_BYTE, 1'b0, BURST_1);
    check("rd_b_s3", got_data[0], 32'hFFFF_FFEF);
    run(BASE + 32'd3, 1'b0, SIZE_BYTE, 1'b1, BURST_1);
    check("rd_b_u3", got_data[0], 32'h0000_00EF);
    run(BASE, 1'b0, SIZE_HALF, 1'b0, BURST_1);
    check("rd_h_s0", got_data[0], 32'hFFFF_DEAD);
    run(BASE + 32'd2, 1'b0, SIZE_HALF, 1'b1, BURST_1);
    check("rd_h_u2", got_data[0], 32'h0000_BEEF);

    // ---------------- sub-word writes merge only their bytes ----------------
    wq[0] = 32'h1234_5655;
    run(BASE + 32'd1, 1'b1, SIZE_BYTE, 1'b0, BURST_1);
    wq[0] = 32'h0000_CAFE;
    run(BASE + 32'd2, 1'b1, SIZE_HALF, 1'b0, BURST_1);
    run(BASE, 1'b0, SIZE_WORD, 1'b0, BURST_1);
    check("merge_word", got_data[0], 32'hDE55_CAFE);
    run(BASE + 32'd1, 1'b0, SIZE_BYTE, 1'b0, BURST_1);
    check("rd_b_s1_pos", got_data[0], 32'h0000_0055);

    // ---------------- burst 4 write then read ----------------
    for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
    run(BASE, 1'b1, SIZE_WORD, 1'b0, BURST_4);
    check("wb4_nbeats", 32'(nbeats), 32'd4);
    check("wb4_last3",  32'(got_last[3]), 32'd1);
    run(BASE, 1'b0, SIZE_WORD, 1'b0, BURST_4);
    check("rb4_nbeats", 32'(nbeats), 32'd4);
    check("rb4_lat",    32'(first_lat), 32'd1);
    check("rb4_span",   32'(last_cyc - first_lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rb4_data%0d", i), got_data[i], 32'(i + 1));
      check($sformatf("rb4_last%0d", i), 32'(got_last[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    // Sub-word access ignores the burst length.
    run(BASE + 32'd3, 1'b0, SIZE_BYTE, 1'b1, BURST_16);
    check("byte_b16_nbeats", 32'(nbeats), 32'd1);
    check("byte_b16_data",   got_data[0], 32'h0000_0001);

    // ---------------- error requests ----------------
    run(32'h8000_0000, 1'b0, SIZE_WORD, 1'b0, BURST_1);
    check("err_lo_nbeats", 32'(nbeats), 32'd1);
    check("err_lo_err",    32'(got_err[0]), 32'd1);
    check("err_lo_last",   32'(got_last[0]), 32'd1);
    check("err_lo_rdata",  got_data[0], 32'd0);
    check("err_lo_lat",    32'(first_lat), 32'd1);
    run(BASE + 32'd1, 1'b0, SIZE_HALF, 1'b0, BURST_1);
    check("err_half_err", 32'(got_err[0]), 32'd1);
    wq[0] = 32'h9999_9999;
    run(BASE + 32'd1, 1'b1, SIZE_HALF, 1'b0, BURST_1);
    check("err_hwr_err", 32'(got_err[0]), 32'd1);
    run(BASE + 32'd2, 1'b1, SIZE_WORD, 1'b0, BURST_4);
    check("err_wwr_err",    32'(got_err[0]), 32'd1);
    check("err_wwr_nbeats", 32'(nbeats), 32'd1);
    run(BASE, 1'b0, SIZE_WORD, 1'b0, BURST_4);
    check("err_nochg0", got_data[0], 32'd1);
    check("err_nochg1", got_data[1], 32'd2);
    run(END_ADDR, 1'b0, SIZE_BYTE, 1'b0, BURST_1);
    check("err_end_err", 32'(got_err[0]), 32'd1);

    // ---------------- storage end ----------------
    wq[0] = 32'hA5A5_0001;
    run(END_ADDR - 32'd4, 1'b1, SIZE_WORD, 1'b0, BURST_1);
    check("top_wr_err", 32'(got_err[0]), 32'd0);
    run(END_ADDR - 32'd8, 1'b0, SIZE_WORD, 1'b0, BURST_8);
    check("cross_nbeats", 32'(nbeats), 32'd3);
    check("cross_d0",     got_data[0], 32'd0);
    check("cross_d1",     got_data[1], 32'hA5A5_0001);
    check("cross_e01",    {30'd0, got_err[1], got_err[0]}, 32'd0);
    check("cross_l01",    {30'd0, got_last[1], got_last[0]}, 32'd0);
    check("cross_e2",     32'(got_err[2]), 32'd1);
    check("cross_l2",     32'(got_last[2]), 32'd1);
    check("cross_d2",     got_data[2], 32'd0);

    // ---------------- reset in the middle of a 16-beat burst ----------------
    for (int i = 0; i < 16; i++) wq[i] = 32'h1111_0000 + 32'(i);
    run(BASE + 32'h40, 1'b1, SIZE_WORD, 1'b0, BURST_16);
    check("wb16_nbeats", 32'(nbeats), 32'd16);
    req_addr = BASE + 32'h40; req_wr = 1'b0; req_size = SIZE_WORD; req_burst = BURST_16;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nbeats = 0; cyc = 0;
    while (nbeats < 5 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        got_data[nbeats] = rsp_rdata;
        nbeats++;
      end
    end
    check("rb16_5beats", 32'(nbeats), 32'd5);
    check("rb16_d4",     got_data[4], 32'h1111_0004);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_last",  32'(rsp_last),  32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_rdata", rsp_rdata,      32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_busy",  32'(busy),      32'd0);
    run(BASE + 32'h40, 1'b0, SIZE_WORD, 1'b0, BURST_4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("keep16_d%0d", i), got_data[i], 32'h1111_0000 + 32'(i));
    end
    run(BASE, 1'b0, SIZE_WORD, 1'b0, BURST_1);
    check("keep_base", got_data[0], 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/burst_mem.md
BURST_MEM -- requirements
Module: burst_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data beat width in bits (multiple of 32).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter MEM_BYTES, default 1048576, storage size in bytes.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h80020000, byte address of storage offset 0.
REQ-005 SHALL have parameter WAIT_CYCLES, default 2, stall cycles per beat when waits compiled in.
REQ-006 SHALL have port clk, input, 1, single clock; all state on posedge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-009 SHALL have ports req_addr (input, ADDR_W), req_wr (input, 1), req_size (input, 2: 0 byte, 1 half, 2 word), req_unsigned (input, 1), req_burst (input, 2: 1/4/8/16 beats).
REQ-010 SHALL have port wdata, input, DATA_W, write data, sampled on each write beat.
REQ-011 SHALL have ports rsp_valid, rsp_last, rsp_err (outputs, 1) and rsp_rdata (output, DATA_W).
REQ-012 SHALL have port busy, output, 1, high whenever not IDLE.

Function
REQ-013 SHALL accept a request only when req_valid && req_ready; req_ready high only in IDLE.
REQ-014 SHALL use states IDLE -> BEAT (-> WAIT -> BEAT with waits) -> IDLE; ERR single-cycle response state.
REQ-015 SHALL produce first rsp_valid exactly 1 cycle after acceptance (no waits), then one beat per cycle.
REQ-016 SHALL address beat n at req_addr + n*(DATA_W/8); offset = address - BASE_ADDR.
REQ-017 SHALL use big-endian order: lowest address byte is MSB of the beat.
REQ-018 SHALL treat req_size byte/half as single-beat regardless of req_burst.
REQ-019 SHALL zero-extend sub-word reads when req_unsigned=1, else sign-extend from lane MSB.
REQ-020 SHALL write only the addressed byte(s) for sub-word writes, taken from wdata LSBs.
REQ-021 SHALL pulse rsp_valid per write beat to acknowledge wdata consumption; rsp_rdata=0 on writes.
REQ-022 SHALL assert rsp_last with the final beat only.
REQ-023 SHALL flag error (addr < BASE_ADDR, beyond BASE_ADDR+MEM_BYTES, half not 2-aligned, word not 4-aligned): no storage access, one beat with rsp_err=1, rsp_last=1, rsp_rdata=0.
REQ-024 SHALL, when a burst crosses the storage end, complete in-range beats, then issue the error beat as last and terminate.
REQ-025 SHALL ignore req_* changes while busy.

Reset
REQ-026 SHALL on rst_n low force IDLE, req_ready=1 after release, rsp_valid/rsp_last/rsp_err/busy=0, rsp_rdata=0, beat counter=0.
REQ-027 SHALL abort any in-flight burst on reset; storage contents SHALL be retained (zero only at time 0).

Configuration
REQ-028 SHALL with BURST_MEM_WAIT_EN defined insert WAIT_CYCLES stall cycles before every beat (busy high, rsp_valid low); without it no WAIT state exists and REQ-015 timing holds.

Structure
REQ-029 SHALL place size/burst encodings, state enum and a beats-from-burst function in package burst_mem_pkg.
REQ-030 SHALL use one sub-module mem_lane_align performing byte-lane extract, extension and write-merge.

Verification
REQ-031 Word write 0xDEADBEEF @0x80020000, then byte read unsigned @0x80020000 -> rsp_rdata=0x000000DE, last=1.
REQ-032 Byte read signed @0x80020003 after REQ-031 -> 0xFFFFFFEF.
REQ-033 Read burst 4 @0x80020000 after writing 1,2,3,4 -> four consecutive beats 1,2,3,4, last on 4th, first beat cycle after accept.
REQ-034 Read @0x80000000 or half @0x80020001 -> single beat rsp_err=1, rsp_rdata=0, no storage change.
REQ-035 Burst 8 @BASE+MEM_BYTES-8 -> 2 good beats then error beat with last=1.
REQ-036 rst_n low mid-burst 16 at beat 5 -> outputs zero, IDLE, prior writes intact on re-read.
